instr_fetch_buffer: RTL and testbench

Decoupling buffer between the fetch stage and the decode stage. It queues fetched instruction packets (instruction word, PC, PC+4) in a small circular FIFO and presents the oldest one to decode, where the opcode field drives the main control decoder. Fetch keeps running while decode stalls, up to DEPTH entries. A redirect from execute empties the buffer in one cycle.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/instr_fetch_buffer.sv | 71 +++++++
 tb/tb_instr_fetch_buffer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch/decode pipeline types: the fetch packet layout and the canonical NOP.
package pipeline_pkg;

  localparam int PKT_WIDTH = 32;

  typedef struct packed {
    logic [31:0]          instr;
    logic [PKT_WIDTH-1:0] pc;
    logic [PKT_WIDTH-1:0] pc_plus4;
  } fetch_pkt_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/instr_fetch_buffer.sv
// Fetch-to-decode circular FIFO: push visible one cycle later (no bypass); flush/reset empty it in one cycle.
// fetch_ready_o comes from registered occupancy only, so a full buffer refuses a push even on a same-cycle pop.
module instr_fetch_buffer
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     fetch_valid_i,
  input  logic [31:0]              instr_f_i,
  input  logic [WIDTH-1:0]         pc_f_i,
  input  logic [WIDTH-1:0]         pc_plus4_f_i,
  output logic                     fetch_ready_o,
  input  logic                     flush_i,
  input  logic                     decode_ready_i,
  output logic                     decode_valid_o,
  output logic [31:0]              instr_d_o,
  output logic [WIDTH-1:0]         pc_d_o,
  output logic [WIDTH-1:0]         pc_plus4_d_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_pkt_t    mem [DEPTH];
  fetch_pkt_t    head_pkt;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign fetch_ready_o  = (count != CW'(DEPTH));
  assign decode_valid_o = (count != '0);
  assign push = fetch_valid_i && fetch_ready_o && !flush_i;
  assign pop  = decode_valid_o && decode_ready_i && !flush_i;

  // Full vs. empty is told apart by count alone; pointers simply wrap.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; stale entries are hidden by count.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      mem[tail] <= '{instr: instr_f_i, pc: pc_f_i, pc_plus4: pc_plus4_f_i};
    end
  end

  assign head_pkt     = mem[head];
  assign instr_d_o    = decode_valid_o ? head_pkt.instr    : NOP_INSTR;
  assign pc_d_o       = decode_valid_o ? head_pkt.pc       : '0;
  assign pc_plus4_d_o = decode_valid_o ? head_pkt.pc_plus4 : '0;
  assign count_o      = count;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed plus randomized checks of instr_fetch_buffer against a queue-based reference model.
module tb_instr_fetch_buffer;
  import pipeline_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              fetch_valid_i;
  logic [31:0]       instr_f_i;
  logic [WIDTH-1:0]  pc_f_i;
  logic [WIDTH-1:0]  pc_plus4_f_i;
  logic              fetch_ready_o;
  logic              flush_i;
  logic              decode_ready_i;
  logic              decode_valid_o;
  logic [31:0]       instr_d_o;
  logic [WIDTH-1:0]  pc_d_o;
  logic [WIDTH-1:0]  pc_plus4_d_o;
  logic [$clog2(DEPTH):0] count_o;

  int vectors = 0;
  int errors  = 0;

  fetch_pkt_t model_q[$];

  instr_fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .fetch_valid_i(fetch_valid_i),
    .instr_f_i(instr_f_i), .pc_f_i(pc_f_i), .pc_plus4_f_i(pc_plus4_f_i),
    .fetch_ready_o(fetch_ready_o), .flush_i(flush_i), .decode_ready_i(decode_ready_i),
    .decode_valid_o(decode_valid_o), .instr_d_o(instr_d_o), .pc_d_o(pc_d_o),
    .pc_plus4_d_o(pc_plus4_d_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs expected from the model's queue contents.
  task automatic check_model(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".valid"}, 32'(decode_valid_o), 32'(n != 0));
    chk({tag, ".ready"}, 32'(fetch_ready_o), 32'(n != DEPTH));
    chk({tag, ".count"}, 32'(count_o), 32'(n));
    chk({tag, ".instr"}, instr_d_o, (n != 0) ? model_q[0].instr : NOP_INSTR);
    chk({tag, ".pc"}, pc_d_o, (n != 0) ? model_q[0].pc : 32'h0);
    chk({tag, ".pc4"}, pc_plus4_d_o, (n != 0) ? model_q[0].pc_plus4 : 32'h0);
  endtask

  // One clock: drive, check current outputs, clock, advance the model.
  task automatic cyc(input string tag, input logic fv, input logic fl, input logic dr,
                     input logic rs, input logic [31:0] pc, input logic [31:0] instr);
    fetch_pkt_t pkt;
    logic       do_push;
    logic       do_pop;
    fetch_valid_i  = fv;
    flush_i        = fl;
    decode_ready_i = dr;
    reset_i        = rs;
    instr_f_i      = instr;
    pc_f_i         = pc;
    pc_plus4_f_i   = pc + 32'd4;
    check_model(tag);
    do_push = fv && (model_q.size() < DEPTH);
    do_pop  = dr && (model_q.size() > 0);
    pkt     = '{instr: instr, pc: pc, pc_plus4: pc + 32'd4};
    @(posedge clk_i);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(pkt);
    end
    #1;
  endtask

  initial begin
    reset_i = 1'b1; fetch_valid_i = 1'b0; flush_i = 1'b0; decode_ready_i = 1'b0;
    instr_f_i = '0; pc_f_i = '0; pc_plus4_f_i = '0;
    @(posedge clk_i); #1;
    model_q.delete();

    // Reset values
    cyc("reset", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("rst.valid", 32'(decode_valid_o), 32'd0);
    chk("rst.ready", 32'(fetch_ready_o), 32'd1);
    chk("rst.instr", instr_d_o, 32'h0000_0013);

    // Single packet, one-cycle latency, then empty again
    cyc("single", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0050_0093);
    chk("single.instr", instr_d_o, 32'h0050_0093);
    chk("single.pc4", pc_plus4_d_o, 32'h4);
    cyc("single_pop", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("single_empty.instr", instr_d_o, 32'h0000_0013);

    // Stall: fill, hold 0x8 in fetch, outputs stable
    cyc("stall0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
    cyc("stall1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h4, $urandom);
    chk("stall.count", 32'(count_o), 32'd2);
    chk("stall.ready", 32'(fetch_ready_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc("stall_hold", 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0000_8888);
      chk("stall_hold.pc", pc_d_o, 32'h0);
    end
    // Full + pop + fetch_valid: pop happens, push refused
    cyc("full_pop", 1'b1, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0000_8888);
    chk("full_pop.count", 32'(count_o), 32'd1);
    chk("full_pop.pc", pc_d_o, 32'h4);
    cyc("rel1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0000_8888);
    chk("rel1.pc", pc_d_o, 32'h8);
    cyc("rel2", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("rel2.valid", 32'(decode_valid_o), 32'd0);

    // Streaming, one in / one out per cycle
    for (int i = 0; i < 16; i++) begin
      cyc("stream", 1'b1, 1'b0, 1'b1, 1'b0, 32'h200 + 32'(4 * i), $urandom);
      chk("stream.pc", pc_d_o, 32'h200 + 32'(4 * i));
    end
    cyc("stream_drain", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    // Flush with simultaneous push and pop
    cyc("fl_fill0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, $urandom);
    cyc("fl_fill1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h14, $urandom);
    cyc("flush", 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, $urandom);
    chk("flush.count", 32'(count_o), 32'd0);
    chk("flush.ready", 32'(fetch_ready_o), 32'd1);
    cyc("post_flush", 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, $urandom);
    chk("post_flush.pc", pc_d_o, 32'h100);
    cyc("post_flush_pop", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    // Reset mid-stream with one entry held
    cyc("rs_fill", 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, $urandom);
    chk("rs_fill.count", 32'(count_o), 32'd1);
    cyc("rs_mid", 1'b1, 1'b0, 1'b1, 1'b1, 32'h304, $urandom);
    chk("rs_mid.valid", 32'(decode_valid_o), 32'd0);
    chk("rs_mid.pc", pc_d_o, 32'h0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      cyc("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0),
          32'h1000 + 32'(4 * i), $urandom);
    end
    cyc("final", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
